seg7_scan_ctrl: RTL

Refresh controller for the 4-digit common-anode seven-segment display. It time-multiplexes four hex digits onto the shared `an`/`seg` pins using a programmable per-digit slot and an anti-ghosting blank gap. New display values are accepted through a valid/ready handshake into a shadow register and applied only at frame boundaries, so a frame never tears. It sits between the application logic and the board display pins and is the only driver of `an` and `seg`.

---
 rtl/seg7_pkg.sv | 51 +++++
 rtl/seg7_scan_ctrl_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment pattern for the scan controller.
package seg7_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 50000;

    // Slot counter width for a given divider; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(CLK_DIV_DEFAULT);

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        ST_GAP = 1'b0,
        ST_ON  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_word_t;

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// Combinational nibble-to-segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] pattern_c
);

    // Pure lookup, no state.
    always_comb begin
        pattern_c = hex7(nib);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment refresh controller with frame-aligned shadow update.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int unsigned GAP_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    output logic        wr_ready,
    output logic        frame_done,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned CW = cnt_width(CLK_DIV);
    localparam scan_state_t ST_SLOT_START = (GAP_CYCLES > 0) ? ST_GAP : ST_ON;

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic          last_cnt_c;
    logic          boundary_c;

    scan_state_t   state;
    scan_state_t   state_next_c;

    disp_word_t    act;
    disp_word_t    pend;
    logic          pend_valid;

    logic [3:0]    nib_c;
    logic [6:0]    pattern_c;
    logic [3:0]    an_c;
    logic [7:0]    seg_c;

    assign last_cnt_c = (cnt == CW'(CLK_DIV - 1));
    assign boundary_c = last_cnt_c && (dig == 2'd3);
    assign wr_ready   = !pend_valid;

    // Slot counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dig <= 2'd0;
        end else if (last_cnt_c) begin
            cnt <= '0;
            dig <= dig + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Slot phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SLOT_START;
        end else begin
            state <= state_next_c;
        end
    end

    // Slot phase transitions: gap first, then the digit is driven until the slot ends.
    always_comb begin
        state_next_c = state;
        if (last_cnt_c) begin
            state_next_c = ST_SLOT_START;
        end else if ((state == ST_GAP) && ((32'(cnt) + 32'd1) == GAP_CYCLES)) begin
            state_next_c = ST_ON;
        end
    end

    // Output decode for the current slot position.
    always_comb begin
        an_c  = AN_OFF;
        seg_c = SEG_OFF;
        nib_c = act.data[{dig, 2'b00} +: 4];
        if ((state == ST_ON) && !act.blank[dig]) begin
            an_c  = ~(4'b0001 << dig);
            seg_c = {~act.dp[dig], pattern_c};
        end
    end

    seg7_hex_decode u_hex_decode (
        .nib       (nib_c),
        .pattern_c (pattern_c)
    );

    // Shadow capture on handshake; active set swapped only at frame boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            act        <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (boundary_c && pend_valid) begin
                act        <= pend;
                pend_valid <= 1'b0;
            end
            if (wr_valid && wr_ready) begin
                pend       <= '{data: wr_data, dp: wr_dp, blank: wr_blank};
                pend_valid <= 1'b1;
            end
        end
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            an         <= an_c;
            seg        <= seg_c;
            frame_done <= boundary_c;
        end
    end

endmodule
